// File: rtl/cfg_loader_pkg.sv
// Shared types and parameter helpers for the configuration stream loader.
// The derived word and beat counts are computed here so top and packer agree.
package cfg_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      WIND,
      DONE
   } state_e;

   function automatic int calc_words(input int dimx, input int dimy, input int port_width);
      return (dimx * dimy * 4) / port_width;
   endfunction

   function automatic int calc_beats(input int port_width, input int in_width);
      return port_width / in_width;
   endfunction

   // A counter for one item still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/beat_packer.sv
// Packs IN_WIDTH stream beats into one PORT_WIDTH word, first beat in the LSBs.
// word is the next-state value so the caller can capture it on the last beat.
module beat_packer
   import cfg_loader_pkg::*;
#(
   parameter int PORT_WIDTH = 32,
   parameter int IN_WIDTH   = 8
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  beat_valid,
   input  logic [IN_WIDTH-1:0]   beat_data,
   output logic [PORT_WIDTH-1:0] word,
   output logic                  word_full
);

   localparam int BEATS = calc_beats(PORT_WIDTH, IN_WIDTH);
   localparam int BCW   = cnt_width(BEATS);

   logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
   logic [PORT_WIDTH-1:0] word_q, word_d;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      word_d     = word_q;
      word_full  = 1'b0;
      if (clear) begin
         beat_cnt_d = '0;
         word_d     = '0;
      end else if (beat_valid) begin
         word_d[int'(beat_cnt_q) * IN_WIDTH +: IN_WIDTH] = beat_data;
         if (beat_cnt_q == BCW'(BEATS - 1)) begin
            word_full  = 1'b1;
            beat_cnt_d = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         beat_cnt_q <= '0;
         word_q     <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         word_q     <= word_d;
      end
   end

   assign word = word_d;

endmodule

// File: rtl/config_stream_loader.sv
// Streams a full cell-array configuration into S2 word by word, then launches
// the array with one S3 wind-up write. All outputs come straight from flops.
module config_stream_loader
   import cfg_loader_pkg::*;
#(
   parameter int DIMX             = 64,
   parameter int DIMY             = 64,
   parameter int PORT_WIDTH       = 32,
   parameter int IN_WIDTH         = 8,
   parameter int S2_ADDRESS_WIDTH = 9,
   parameter int COUNTER_BIT      = 16
) (
   input  logic                        clk_in,
   input  logic                        rst,
   input  logic                        start,
   input  logic [COUNTER_BIT-1:0]      wind_count,
   input  logic                        abort,
   input  logic                        in_valid,
   input  logic [IN_WIDTH-1:0]         in_data,
   output logic                        in_ready,
   output logic                        s2_write,
   output logic [S2_ADDRESS_WIDTH-1:0] s2_address,
   output logic [PORT_WIDTH-1:0]       s2_writedata,
   output logic                        s3_write,
   output logic [COUNTER_BIT-1:0]      s3_writedata,
   output logic                        busy,
   output logic                        done
);

   localparam int WORDS = calc_words(DIMX, DIMY, PORT_WIDTH);

   if (PORT_WIDTH % IN_WIDTH != 0) begin : g_bad_beats
      $error("PORT_WIDTH must be a multiple of IN_WIDTH");
   end
   if ((DIMX * DIMY * 4) % PORT_WIDTH != 0) begin : g_bad_words
      $error("array bit count must be a multiple of PORT_WIDTH");
   end
   if (64'(WORDS) > (64'(1) << S2_ADDRESS_WIDTH)) begin : g_bad_addr
      $error("S2_ADDRESS_WIDTH too narrow for WORDS");
   end

   state_e                      state_q, state_d;
   logic [S2_ADDRESS_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [COUNTER_BIT-1:0]      wind_q, wind_d;
   logic                        in_ready_q, in_ready_d;
   logic                        s2_write_q, s2_write_d;
   logic [S2_ADDRESS_WIDTH-1:0] s2_address_q, s2_address_d;
   logic [PORT_WIDTH-1:0]       s2_writedata_q, s2_writedata_d;
   logic                        s3_write_q, s3_write_d;
   logic [COUNTER_BIT-1:0]      s3_writedata_q, s3_writedata_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;

   logic                        pk_clear, pk_full;
   logic [PORT_WIDTH-1:0]       pk_word;

   beat_packer #(
      .PORT_WIDTH (PORT_WIDTH),
      .IN_WIDTH   (IN_WIDTH)
   ) u_packer (
      .clk_in     (clk_in),
      .rst        (rst),
      .clear      (pk_clear),
      .beat_valid (in_valid && in_ready_q),
      .beat_data  (in_data),
      .word       (pk_word),
      .word_full  (pk_full)
   );

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      wind_d     = wind_q;
      pk_clear   = 1'b0;
      unique case (state_q)
         IDLE: if (start && !abort) begin
            state_d    = LOAD;
            wind_d     = wind_count;
            word_cnt_d = '0;
            pk_clear   = 1'b1;
         end
         LOAD:  if (pk_full) state_d = WRITE;
         WRITE: if (word_cnt_q == S2_ADDRESS_WIDTH'(WORDS - 1)) begin
            state_d = WIND;
         end else begin
            state_d    = LOAD;
            word_cnt_d = word_cnt_q + S2_ADDRESS_WIDTH'(1);
         end
         WIND:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) state_d = IDLE;

      // Outputs are registered from the next state, so an abort drops any pending strobe.
      in_ready_d     = (state_d == LOAD);
      busy_d         = (state_d == LOAD) || (state_d == WRITE) || (state_d == WIND);
      done_d         = (state_d == DONE);
      s2_write_d     = (state_d == WRITE);
      s2_address_d   = s2_write_d ? word_cnt_q : s2_address_q;
      s2_writedata_d = s2_write_d ? pk_word : s2_writedata_q;
      s3_write_d     = (state_d == WIND);
      s3_writedata_d = s3_write_d ? wind_q : s3_writedata_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q        <= IDLE;
         word_cnt_q     <= '0;
         wind_q         <= '0;
         in_ready_q     <= 1'b0;
         s2_write_q     <= 1'b0;
         s2_address_q   <= '0;
         s2_writedata_q <= '0;
         s3_write_q     <= 1'b0;
         s3_writedata_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         word_cnt_q     <= word_cnt_d;
         wind_q         <= wind_d;
         in_ready_q     <= in_ready_d;
         s2_write_q     <= s2_write_d;
         s2_address_q   <= s2_address_d;
         s2_writedata_q <= s2_writedata_d;
         s3_write_q     <= s3_write_d;
         s3_writedata_q <= s3_writedata_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign s2_write     = s2_write_q;
   assign s2_address   = s2_address_q;
   assign s2_writedata = s2_writedata_q;
   assign s3_write     = s3_write_q;
   assign s3_writedata = s3_writedata_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader with an 8x2 array (two 32-bit words).
// Cycle n below means the clock period that follows edge n-1 after the start edge.
module tb_config_stream_loader;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [15:0] wind_count = '0;
   logic [7:0]  in_data = '0;
   logic        in_ready, s2_write, s3_write, busy, done;
   logic [8:0]  s2_address;
   logic [31:0] s2_writedata;
   logic [15:0] s3_writedata;

   config_stream_loader #(
      .DIMX(8), .DIMY(2), .PORT_WIDTH(32), .IN_WIDTH(8),
      .S2_ADDRESS_WIDTH(9), .COUNTER_BIT(16)
   ) dut (
      .clk_in(clk_in), .rst(rst), .start(start), .wind_count(wind_count),
      .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .s2_write(s2_write), .s2_address(s2_address), .s2_writedata(s2_writedata),
      .s3_write(s3_write), .s3_writedata(s3_writedata), .busy(busy), .done(done)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   int start_edge = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   logic [8:0]  s2a_q[$];
   logic [31:0] s2d_q[$];
   int          s2c_q[$];
   logic [15:0] s3d_q[$];
   int          s3c_q[$];
   int          dnc_q[$];
   int          b2b_err = 0, ovl_err = 0;
   logic        prev_s2 = 1'b0;

   always @(negedge clk_in) begin
      if (s2_write === 1'b1) begin
         s2a_q.push_back(s2_address);
         s2d_q.push_back(s2_writedata);
         s2c_q.push_back(cyc - start_edge + 1);
         if (prev_s2) b2b_err++;
         if (in_ready === 1'b1) ovl_err++;
      end
      if (s3_write === 1'b1) begin
         s3d_q.push_back(s3_writedata);
         s3c_q.push_back(cyc - start_edge + 1);
      end
      if (done === 1'b1) dnc_q.push_back(cyc - start_edge + 1);
      prev_s2 = (s2_write === 1'b1);
   end

   int n_chk = 0, n_pass = 0;
   int s2_b = 0, s3_b = 0, dn_b = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_start(input logic [15:0] wc);
      wind_count = wc;
      start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      start_edge = cyc;
      s2_b = s2a_q.size();
      s3_b = s3d_q.size();
      dn_b = dnc_q.size();
      check("busy_c1", busy, 1);
      check("in_ready_c1", in_ready, 1);
   endtask

   // Offers n beats base, base+1, ...; gap drives valid only on odd cycles.
   task automatic drive(input logic [7:0] base, input int n, input bit gap);
      int  b = 0, guard = 0, c = 1;
      bit  hs;
      while (b < n && guard < 200) begin
         in_valid = !gap || (c % 2 == 1);
         in_data  = base + 8'(b);
         @(negedge clk_in);
         hs = in_valid && in_ready;
         @(posedge clk_in); #1;
         c++; guard++;
         if (hs) b++;
      end
      in_valid = 1'b0;
      if (b < n) check("drive_timeout", b, n);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (dnc_q.size() == dn_b && k < 100) begin
         @(posedge clk_in); #1;
         k++;
      end
      check({tag, "_done_cnt"}, dnc_q.size() - dn_b, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_s2_write"}, s2_write, 0);
      check({tag, "_s2_address"}, s2_address, 0);
      check({tag, "_s2_writedata"}, s2_writedata, 0);
      check({tag, "_s3_write"}, s3_write, 0);
      check({tag, "_s3_writedata"}, s3_writedata, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk_in);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk_in); #1;

      // Full load, valid held high
      do_start(16'h0010);
      drive(8'h01, 8, 1'b0);
      wait_done("full");
      check("full_s2_cnt", s2a_q.size() - s2_b, 2);
      check("full_a0", s2a_q[s2_b], 0);
      check("full_d0", s2d_q[s2_b], 32'h04030201);
      check("full_c0", s2c_q[s2_b], 5);
      check("full_a1", s2a_q[s2_b+1], 1);
      check("full_d1", s2d_q[s2_b+1], 32'h08070605);
      check("full_c1", s2c_q[s2_b+1], 10);
      check("full_s3_cnt", s3d_q.size() - s3_b, 1);
      check("full_s3_d", s3d_q[s3_b], 16'h0010);
      check("full_s3_c", s3c_q[s3_b], 11);
      check("full_done_c", dnc_q[dn_b], 12);
      check("full_busy_after", busy, 0);
      check("full_done_pulse", done, 0);
      check("full_addr_hold", s2_address, 1);
      check("full_data_hold", s2_writedata, 32'h08070605);
      check("full_s3d_hold", s3_writedata, 16'h0010);

      // Gapped stream with wind_count 0
      do_start(16'h0000);
      drive(8'h11, 8, 1'b1);
      wait_done("gap");
      check("gap_s2_cnt", s2a_q.size() - s2_b, 2);
      check("gap_a0", s2a_q[s2_b], 0);
      check("gap_d0", s2d_q[s2_b], 32'h14131211);
      check("gap_c0", s2c_q[s2_b], 8);
      check("gap_a1", s2a_q[s2_b+1], 1);
      check("gap_d1", s2d_q[s2_b+1], 32'h18171615);
      check("gap_c1", s2c_q[s2_b+1], 16);
      check("gap_s3_cnt", s3d_q.size() - s3_b, 1);
      check("gap_s3_d", s3d_q[s3_b], 16'h0000);
      check("gap_s3_c", s3c_q[s3_b], 17);
      check("gap_done_c", dnc_q[dn_b], 18);

      // Abort after two beats of word 1, then a fresh load
      do_start(16'h0077);
      drive(8'h41, 6, 1'b0);
      abort = 1'b1;
      @(posedge clk_in); #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      in_valid = 1'b1;
      repeat (6) @(posedge clk_in);
      #1;
      in_valid = 1'b0;
      check("abort_in_ready_idle", in_ready, 0);
      check("abort_s2_cnt", s2a_q.size() - s2_b, 1);
      check("abort_d0", s2d_q[s2_b], 32'h44434241);
      check("abort_s3_cnt", s3d_q.size() - s3_b, 0);
      check("abort_done_cnt", dnc_q.size() - dn_b, 0);
      do_start(16'h0055);
      drive(8'h21, 8, 1'b0);
      wait_done("reload");
      check("reload_s2_cnt", s2a_q.size() - s2_b, 2);
      check("reload_a0", s2a_q[s2_b], 0);
      check("reload_d0", s2d_q[s2_b], 32'h24232221);
      check("reload_a1", s2a_q[s2_b+1], 1);
      check("reload_d1", s2d_q[s2_b+1], 32'h28272625);
      check("reload_s3_d", s3d_q[s3_b], 16'h0055);

      // Second start while busy is ignored
      do_start(16'h1234);
      drive(8'h31, 3, 1'b0);
      wind_count = 16'hFFFF;
      start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      check("rebusy_busy", busy, 1);
      drive(8'h34, 5, 1'b0);
      wait_done("rebusy");
      check("rebusy_s2_cnt", s2a_q.size() - s2_b, 2);
      check("rebusy_d0", s2d_q[s2_b], 32'h34333231);
      check("rebusy_d1", s2d_q[s2_b+1], 32'h38373635);
      check("rebusy_s3_cnt", s3d_q.size() - s3_b, 1);
      check("rebusy_s3_d", s3d_q[s3_b], 16'h1234);
      check("rebusy_s3_out", s3_writedata, 16'h1234);

      // Reset while the first S2 write is on the bus
      do_start(16'h0099);
      drive(8'h51, 4, 1'b0);
      check("rst_pre_s2", s2_write, 1);
      rst = 1'b1;
      @(posedge clk_in); #1;
      check_all_zero("midrst");
      rst = 1'b0;
      in_valid = 1'b1;
      repeat (5) @(posedge clk_in);
      #1;
      in_valid = 1'b0;
      check("midrst_in_ready_idle", in_ready, 0);
      check("midrst_busy_idle", busy, 0);
      check("midrst_s2_cnt", s2a_q.size() - s2_b, 1);
      check("midrst_s3_cnt", s3d_q.size() - s3_b, 0);
      check("midrst_done_cnt", dnc_q.size() - dn_b, 0);

      check("s2_back_to_back", b2b_err, 0);
      check("in_ready_in_write", ovl_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/config_stream_loader.md
# config_stream_loader

Sequencer that sits directly upstream of the logical cell array's S2 (cell RAM) and S3 (wind-up clock) slave ports. It accepts a narrow valid/ready byte stream carrying a full array configuration and packs it into PORT_WIDTH words. It issues one S2 write per slot, at addresses 0..WORDS-1 in order, then issues a single S3 write carrying the requested run length. This lets a DMA/FIFO source load and launch the array without per-word software writes.

## Interface
- DIMX, 64, cell array width
- DIMY, 64, cell array height
- PORT_WIDTH, 32, S2 data width; multiple of IN_WIDTH
- IN_WIDTH, 8, stream beat width
- S2_ADDRESS_WIDTH, 9, must satisfy 2^S2_ADDRESS_WIDTH ≥ WORDS
- COUNTER_BIT, 16, wind-up counter width
- Derived: WORDS = DIMX*DIMY*4/PORT_WIDTH; BEATS = PORT_WIDTH/IN_WIDTH

Ports:
- clk_in  in  1  single clock; every register in the block is clocked on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; ignored unless IDLE
- wind_count  in  COUNTER_BIT  run length, sampled on accepted start
- abort  in  1  cancel the load in progress
- in_valid  in  1  stream beat valid
- in_data  in  IN_WIDTH  stream beat
- in_ready  out  1  stream beat accepted when in_valid&&in_ready
- s2_write  out  1  S2 write strobe, one cycle per word
- s2_address  out  S2_ADDRESS_WIDTH  slot address
- s2_writedata  out  PORT_WIDTH  packed word
- s3_write  out  1  S3 write strobe
- s3_writedata  out  COUNTER_BIT  latched wind_count
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse on successful completion

## Operation
- All outputs are registered. Reset values: in_ready=0, s2_write=0, s2_address=0, s2_writedata=0, s3_write=0, s3_writedata=0, busy=0, done=0. The state machine resets to IDLE.
- States:
  - IDLE: start → LOAD. On that transition, latch wind_count, clear beat counter and word counter.
  - LOAD: in_ready=1. Each accepted beat is written into word bits [b*IN_WIDTH +: IN_WIDTH], where b is the beat index; the first beat goes to the LSBs. After BEATS beats → WRITE.
  - WRITE: one cycle with s2_write=1, s2_address=word counter, and s2_writedata = the packed word; in_ready=0. If word counter == WORDS-1 → WIND; otherwise increment the word counter → LOAD.
  - WIND: one cycle with s3_write=1 and s3_writedata = the latched count → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- s2_writedata and s2_address hold their last values outside WRITE. s3_writedata holds its value after WIND.
- in_valid low stalls the beat counter; there is no timeout.
- wind_count=0 is still written via S3.
- abort in any non-IDLE state → IDLE on the next edge:
  - in_ready=0, busy=0, no done pulse, no s3_write.
  - Words already written remain in the array.
  - abort in the same cycle as WRITE/WIND suppresses the pending strobe.
- start coincident with abort while IDLE: abort wins; stay in IDLE.
- rst mid-operation behaves like abort, and additionally clears every output register.

## Timing
- Reference case: start accepted at edge 0, in_valid held high, BEATS=4.
  - busy=1 and in_ready=1 from cycle 1.
  - Beats for word k are accepted at cycles 5k+1 .. 5k+4.
  - s2_write for word k is asserted at cycle 5k+5.
  - s3_write at cycle 5·WORDS+1; done at 5·WORDS+2.
- Throughput: BEATS+1 cycles per word.
- s2_* strobes are exactly one cycle wide and never back-to-back; the S2 decoder needs no hold.

## Structure
- Package cfg_loader_pkg: state enum (IDLE, LOAD, WRITE, WIND, DONE), and functions computing WORDS and BEATS from the parameters.
- Elaboration-time checks: PORT_WIDTH % IN_WIDTH == 0; (DIMX*DIMY*4) % PORT_WIDTH == 0; address width sufficient for WORDS.
- One sub-module, beat_packer: beat counter plus word register; outputs word_full. The top level holds the FSM, the word counter, and the S3 latch.

## Test plan
Bench parameters: DIMX=8, DIMY=2, PORT_WIDTH=32, IN_WIDTH=8 → WORDS=2.
- Full load: start with wind_count=0x0010; stream 8 beats 0x01..0x08 with valid held high. Expect s2 writes (addr 0, 0x04030201) at cycle 5 and (addr 1, 0x08070605) at cycle 10; s3_write 0x0010 at cycle 11; done at cycle 12.
- Gapped stream: toggle in_valid every other cycle. Expect the same words and addresses; the write for a word comes one cycle after its 4th accepted beat; in_ready never rises in WRITE.
- Abort during LOAD of word 1 after 2 beats. Expect busy=0 on the next cycle, no second s2_write, no s3_write, no done. A fresh start then rewrites from address 0.
- Start while busy: assert start again mid-load with wind_count=0xFFFF. Expect it ignored; s3_writedata equals the originally latched value.
- Reset mid-WRITE cycle: expect all outputs 0 on the next edge, no strobe leaking, state IDLE.
